spi_master_arbiter: RTL

Two-requester SPI master that shares one serial bus among up to `NUM_SLAVES` register-file slaves. It arbitrates between two parallel command ports, serialises each granted command into the fixed 17-bit frame: R/W bit, 8-bit address, then 8-bit data. It drives the selected slave's active-low select and returns read data on the shared `rdata` bus. It sits between on-chip bus masters and the SPI slave array, and is the only driver of `mosi` and `ss_n`.

---
 rtl/spi_master_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: two-port command arbiter and SPI frame master.
// Each granted command becomes one 17-bit frame: R/W bit, 8-bit address and 8-bit data.
// Two trailing zero bits follow, so each frame holds one slave select low for 19 cycles.
// Optional feature: define SPI_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, arbitration is fixed priority and requester 0 wins a tie.
module spi_master_arbiter #(
    parameter int NUM_SLAVES = 2,
    parameter int SEL_W      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [15:0]           addr_i,
    input  logic [15:0]           wdata_i,
    input  logic [2*SEL_W-1:0]    sel_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            done_o,
    output logic [7:0]            rdata_o,
    output logic [NUM_SLAVES-1:0] ss_n_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [NUM_SLAVES-1:0] SS_IDLE  = {NUM_SLAVES{1'b1}};
    localparam logic [4:0]            CNT_LAST = 5'd18;
    localparam logic [4:0]            RX_FIRST = 5'd9;
    localparam logic [4:0]            RX_LAST  = 5'd16;

    // One-cold select pattern for a slave index; out-of-range indices give all ones.
    function automatic logic [NUM_SLAVES-1:0] decode_ss(input logic [SEL_W-1:0] s);
        logic [NUM_SLAVES-1:0] v;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            v[i] = (s == SEL_W'(i)) ? 1'b0 : 1'b1;
        end
        return v;
    endfunction

    state_t                state_q;
    logic [4:0]            cnt_q;
    logic                  win_q;
    logic                  we_q;
    logic [16:0]           tx_q;
    logic [7:0]            rx_q;
    logic [NUM_SLAVES-1:0] ss_sel_q;
    logic [1:0]            gnt_q;
    logic [1:0]            done_q;
    logic [7:0]            rdata_q;
    logic [NUM_SLAVES-1:0] ss_n_q;
    logic                  mosi_q;
`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic                  ptr_q;
`endif

    logic                  win_d;
    logic                  we_win_d;
    logic [7:0]            addr_win_d;
    logic [7:0]            wdata_win_d;
    logic [SEL_W-1:0]      sel_win_d;

    // Pick the winning requester and steer its command fields toward the shadow registers.
    always_comb begin
        win_d       = 1'b0;
        we_win_d    = 1'b0;
        addr_win_d  = 8'h00;
        wdata_win_d = 8'h00;
        sel_win_d   = {SEL_W{1'b0}};
`ifdef SPI_ARB_ROUND_ROBIN_EN
        if (req_i == 2'b11) begin
            win_d = ptr_q;
        end else if (req_i[0]) begin
            win_d = 1'b0;
        end else begin
            win_d = 1'b1;
        end
`else
        if (req_i[0]) begin
            win_d = 1'b0;
        end else begin
            win_d = 1'b1;
        end
`endif
        if (win_d) begin
            we_win_d    = we_i[1];
            addr_win_d  = addr_i[15:8];
            wdata_win_d = wdata_i[15:8];
            sel_win_d   = sel_i[2*SEL_W-1:SEL_W];
        end else begin
            we_win_d    = we_i[0];
            addr_win_d  = addr_i[7:0];
            wdata_win_d = wdata_i[7:0];
            sel_win_d   = sel_i[SEL_W-1:0];
        end
    end

    // Frame sequencer: grants, serialises the frame, captures read data and drives every output.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            tx_q     <= 17'd0;
            rx_q     <= 8'h00;
            ss_sel_q <= SS_IDLE;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            rdata_q  <= 8'h00;
            ss_n_q   <= SS_IDLE;
            mosi_q   <= 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    ss_n_q <= SS_IDLE;
                    mosi_q <= 1'b0;
                    done_q <= 2'b00;
                    if (req_i != 2'b00) begin
                        // The grant pulse is registered, so the winner's command is
                        // captured here and is held in the shadows for the whole GRANT cycle.
                        state_q  <= S_GRANT;
                        gnt_q    <= win_d ? 2'b10 : 2'b01;
                        win_q    <= win_d;
                        we_q     <= we_win_d;
                        tx_q     <= {we_win_d, addr_win_d, (we_win_d ? wdata_win_d : 8'h00)};
                        ss_sel_q <= decode_ss(sel_win_d);
`ifdef SPI_ARB_ROUND_ROBIN_EN
                        ptr_q    <= ~win_d;
`endif
                    end else begin
                        gnt_q <= 2'b00;
                    end
                end
                S_GRANT: begin
                    gnt_q   <= 2'b00;
                    cnt_q   <= 5'd0;
                    ss_n_q  <= ss_sel_q;
                    mosi_q  <= tx_q[16];
                    tx_q    <= {tx_q[15:0], 1'b0};
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    // Once all 17 frame bits have been shifted out, only zeros reach mosi.
                    mosi_q <= tx_q[16];
                    tx_q   <= {tx_q[15:0], 1'b0};
                    // The slave drives read bit k while cnt is 9+k. That bit is sampled
                    // at the edge that advances cnt to 10+k.
                    if ((cnt_q >= RX_FIRST) && (cnt_q <= RX_LAST)) begin
                        rx_q <= {rx_q[6:0], miso_i};
                    end else begin
                        rx_q <= rx_q;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_DONE;
                        ss_n_q  <= SS_IDLE;
                        mosi_q  <= 1'b0;
                        done_q  <= win_q ? 2'b10 : 2'b01;
                        if (!we_q) begin
                            // With no slave selected, nothing drives miso, so a fixed all-ones value is returned.
                            rdata_q <= (ss_sel_q != SS_IDLE) ? rx_q : 8'hFF;
                        end else begin
                            rdata_q <= rdata_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 2'b00;
                    ss_n_q  <= SS_IDLE;
                    mosi_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    gnt_q   <= 2'b00;
                    done_q  <= 2'b00;
                    ss_n_q  <= SS_IDLE;
                    mosi_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign ss_n_o  = ss_n_q;
    assign mosi_o  = mosi_q;

endmodule
